// File: rtl/swt16_dmem_pkg.sv
// Shared definitions for the swt16 data-memory responder: default geometry,
// clear-FSM state encodings and the alignment check used on request addresses.
package swt16_dmem_pkg;

    localparam int DMEM_ADDR_WIDTH_DEF = 12;
    localparam int DMEM_WORD_WIDTH_DEF = 16;
    localparam int DMEM_DEPTH_DEF      = 2048;

    typedef enum logic {
        DMEM_ST_CLEAR = 1'b0,
        DMEM_ST_READY = 1'b1
    } dmem_state_e;

    // Words are 16-bit, so an odd byte address cannot name a whole word.
    function automatic logic dmem_misaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-write, single-read synchronous word array with registered read data;
// a same-index write and read in one cycle returns the data being written.
module dmem_ram
    import swt16_dmem_pkg::*;
#(
    parameter int IDX_W  = DMEM_ADDR_WIDTH_DEF - 1,
    parameter int DATA_W = DMEM_WORD_WIDTH_DEF,
    parameter int DEPTH  = DMEM_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it can map onto block RAM; only the read register is reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: load/store decode, misalignment errors and 1-cycle load data.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole array after reset while holding out_busy.
module dmem_resp
    import swt16_dmem_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF,
    parameter int DMEM_DEPTH      = DMEM_DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    output logic [DMEM_WORD_WIDTH-1:0] out_rd_word,
    output logic                       out_rd_valid,
    output logic                       out_access_err,
    output logic                       out_busy
);

    localparam int IDX_W = DMEM_ADDR_WIDTH - 1;

    logic             ready;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

`ifdef DMEM_CLEAR_ON_RESET_EN
    dmem_state_e      state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             busy_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DMEM_ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                DMEM_ST_CLEAR: begin
                    if (cnt_q == IDX_W'(DMEM_DEPTH - 1)) begin
                        state_q <= DMEM_ST_READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready    = (state_q == DMEM_ST_READY);
    assign clr_we   = (state_q == DMEM_ST_CLEAR);
    assign clr_idx  = cnt_q;
    assign out_busy = busy_q;
`else
    assign ready    = 1'b1;
    assign clr_we   = 1'b0;
    assign clr_idx  = '0;
    assign out_busy = 1'b0;
`endif

    logic rd_mis, wr_mis, rd_ok, wr_ok;
    logic valid_q, err_q;

    assign rd_mis = in_act_load_dmem  & dmem_misaligned(in_dmem_rd_addr[0]);
    assign wr_mis = in_act_store_dmem & dmem_misaligned(in_dmem_wr_addr[0]);
    assign rd_ok  = ready & in_act_load_dmem  & ~rd_mis;
    assign wr_ok  = ready & in_act_store_dmem & ~wr_mis;

    // The clear sequence owns the write port; requests are already gated off by ready.
    logic                       ram_we;
    logic [IDX_W-1:0]           ram_waddr;
    logic [DMEM_WORD_WIDTH-1:0] ram_wdata;

    assign ram_we    = clr_we | wr_ok;
    assign ram_waddr = clr_we ? clr_idx : in_dmem_wr_addr[DMEM_ADDR_WIDTH-1:1];
    assign ram_wdata = clr_we ? '0 : in_dmem_wr_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            err_q   <= ready & (rd_mis | wr_mis);
        end
    end

    dmem_ram #(
        .IDX_W  (IDX_W),
        .DATA_W (DMEM_WORD_WIDTH),
        .DEPTH  (DMEM_DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_ok),
        .raddr_i (in_dmem_rd_addr[DMEM_ADDR_WIDTH-1:1]),
        .rdata_o (out_rd_word)
    );

    assign out_rd_valid   = valid_q;
    assign out_access_err = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp; clear-on-reset scenarios run only when
// DMEM_CLEAR_ON_RESET_EN is defined for the build.
module tb_dmem_resp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld    = 1'b0;
    logic        st    = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [11:0] wr_addr = '0;
    logic [15:0] wr_word = '0;
    logic [15:0] rd_word;
    logic        rd_valid, acc_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    dmem_resp dut (
        .clock             (clock),
        .reset             (reset),
        .in_act_load_dmem  (ld),
        .in_act_store_dmem (st),
        .in_dmem_rd_addr   (rd_addr),
        .in_dmem_wr_addr   (wr_addr),
        .in_dmem_wr_word   (wr_word),
        .out_rd_word       (rd_word),
        .out_rd_valid      (rd_valid),
        .out_access_err    (acc_err),
        .out_busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ld = 1'b0;
        st = 1'b0;
    endtask

    task automatic do_load(input logic [11:0] a);
        ld      = 1'b1;
        rd_addr = a;
    endtask

    task automatic do_store(input logic [11:0] a, input logic [15:0] d);
        st      = 1'b1;
        wr_addr = a;
        wr_word = d;
    endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
    // Counts busy cycles after reset release; optionally injects requests that must be ignored.
    task automatic wait_clear(input int inject_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (n == inject_at) begin
                do_store(12'h004, 16'hAAAA);
                do_load(12'h010);
            end else if (n == inject_at + 1) begin
                idle();
                do_load(12'h011);
            end else begin
                idle();
            end
            tick();
            n++;
            if (n == inject_at + 1) check("clear_ld_ignored", {31'd0, rd_valid}, 32'd0);
            if (n == inject_at + 2) check("clear_err_ignored", {31'd0, acc_err}, 32'd0);
        end
        idle();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_word",  {16'd0, rd_word},  32'h0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_err",   {31'd0, acc_err},  32'd0);
        check("rst_busy",  {31'd0, busy},     {31'd0, BUSY_RST});
        reset = 1'b0;

`ifdef DMEM_CLEAR_ON_RESET_EN
        wait_clear(10, n);
        check("clear_len", n, 32'd2048);
        check("busy_low", {31'd0, busy}, 32'd0);
        do_load(12'h000); tick(); idle();
        check("clr_ld0_valid", {31'd0, rd_valid}, 32'd1);
        check("clr_ld0_word",  {16'd0, rd_word},  32'h0);
        do_load(12'hFFE); tick(); idle();
        check("clr_ldtop_word", {16'd0, rd_word}, 32'h0);
`endif

        // Store then load one cycle later.
        do_store(12'h010, 16'hBEEF); tick(); idle();
        check("st_only_valid", {31'd0, rd_valid}, 32'd0);
        do_load(12'h010); tick(); idle();
        check("ld_valid", {31'd0, rd_valid}, 32'd1);
        check("ld_word",  {16'd0, rd_word},  32'hBEEF);
        tick();
        check("ld_pulse", {31'd0, rd_valid}, 32'd0);
        check("ld_hold",  {16'd0, rd_word},  32'hBEEF);

        // Same-cycle store and load to one index: write-first.
        do_store(12'h020, 16'h1234); do_load(12'h020); tick(); idle();
        check("wf_valid", {31'd0, rd_valid}, 32'd1);
        check("wf_word",  {16'd0, rd_word},  32'h1234);
        do_load(12'h020); tick(); idle();
        check("wf_array", {16'd0, rd_word}, 32'h1234);

        // Same-cycle store and load to different indices.
        do_store(12'h030, 16'h0042); do_load(12'h010); tick(); idle();
        check("diff_ld",  {16'd0, rd_word}, 32'hBEEF);
        do_load(12'h030); tick(); idle();
        check("diff_st",  {16'd0, rd_word}, 32'h0042);

        // Misaligned load.
        do_load(12'h011); tick(); idle();
        check("misld_err",   {31'd0, acc_err},  32'd1);
        check("misld_valid", {31'd0, rd_valid}, 32'd0);
        check("misld_word",  {16'd0, rd_word},  32'h0042);
        tick();
        check("misld_pulse", {31'd0, acc_err}, 32'd0);

        // Misaligned store must not touch array[9].
        do_store(12'h012, 16'h7777); tick(); idle();
        check("st9_err", {31'd0, acc_err}, 32'd0);
        do_store(12'h013, 16'h5555); tick(); idle();
        check("misst_err", {31'd0, acc_err}, 32'd1);
        do_load(12'h012); tick(); idle();
        check("misst_array", {16'd0, rd_word}, 32'h7777);
        check("misst_pulse", {31'd0, acc_err}, 32'd0);

        // Both misaligned in one cycle: one error pulse, array untouched.
        do_load(12'h031); do_store(12'h021, 16'hFFFF); tick(); idle();
        check("both_err",   {31'd0, acc_err},  32'd1);
        check("both_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        check("both_pulse", {31'd0, acc_err}, 32'd0);
        do_load(12'h020); tick(); idle();
        check("both_array", {16'd0, rd_word}, 32'h1234);

        // Back-to-back loads, one result per cycle.
        do_load(12'h010); tick();
        check("b2b0", {15'd0, rd_valid, rd_word}, {16'd1, 16'hBEEF});
        do_load(12'h020); tick();
        check("b2b1", {15'd0, rd_valid, rd_word}, {16'd1, 16'h1234});
        do_load(12'h030); tick(); idle();
        check("b2b2", {15'd0, rd_valid, rd_word}, {16'd1, 16'h0042});
        tick();
        check("b2b_end", {31'd0, rd_valid}, 32'd0);

`ifdef DMEM_CLEAR_ON_RESET_EN
        // Reset in the middle of a clear restarts it from index 0.
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_busy", {31'd0, busy}, 32'd1);
        check("rst2_word", {16'd0, rd_word}, 32'h0);
        for (int i = 0; i < 1000; i++) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        wait_clear(-10, n);
        check("reclear_len", n, 32'd2048);
        do_load(12'h010); tick(); idle();
        check("reclear_beef", {16'd0, rd_word}, 32'h0);
        do_load(12'h004); tick(); idle();
        check("clear_st_ignored", {16'd0, rd_word}, 32'h0);
`else
        reset = 1'b1; tick();
        check("rst2_word",  {16'd0, rd_word},  32'h0);
        check("rst2_valid", {31'd0, rd_valid}, 32'd0);
        check("rst2_busy",  {31'd0, busy},     32'd0);
        reset = 1'b0; tick();
        do_load(12'h010); tick(); idle();
        check("post_rst_ld", {16'd0, rd_word}, 32'hBEEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the swt16 pipeline: accepts load/store requests driven combinationally by the execute stage, performs them against an on-chip word array, and returns load data one cycle later to the write-back side. Optionally clears the whole array after reset, signalling busy so the pipeline stalls until memory is usable. Sits between the execute stage's dmem request outputs and the write-back stage's load-data input.

## Interface
- DMEM_ADDR_WIDTH, 12, byte-address width of request addresses
- DMEM_WORD_WIDTH, 16, data word width
- DMEM_DEPTH, 2048, number of words; equals 2^(DMEM_ADDR_WIDTH-1)

Ports:
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- in_act_load_dmem  in  1  load request this cycle
- in_act_store_dmem  in  1  store request this cycle
- in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load byte address
- in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store byte address
- in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
- out_rd_word  out  DMEM_WORD_WIDTH  load data, valid with out_rd_valid
- out_rd_valid  out  1  one-cycle pulse, load data present
- out_access_err  out  1  one-cycle pulse, misaligned request dropped
- out_busy  out  1  memory not accepting requests; pipeline must stall

## Operation
- Addressing: word index = addr[DMEM_ADDR_WIDTH-1:1]; addr[0]=1 is misaligned.
- Misaligned load or store: no array access, out_rd_valid stays 0, out_access_err=1 next cycle. Both misaligned in one cycle still yields a single pulse.
- Store: array[wr index] <= in_dmem_wr_word at rising edge.
- Load: out_rd_word <= array[rd index], out_rd_valid <= 1 at rising edge.
- Load and store in same cycle to same index: write-first; load returns in_dmem_wr_word. Different indices: both performed independently.
- No request: out_rd_valid <= 0; out_rd_word holds last value.
- FSM (macro enabled): CLEAR -> READY.
  - CLEAR: counter from 0 to DMEM_DEPTH-1, writes 0 to array[counter] each cycle; out_busy=1; all requests ignored (no write, no rd_valid, no err).
  - After writing index DMEM_DEPTH-1, next state READY; out_busy=0 from that cycle on.
  - READY: serve requests; stays until reset.
- Reset, including mid-CLEAR: state CLEAR, counter 0, clearing restarts from index 0.

## Timing
- Reset values: out_rd_word 0, out_rd_valid 0, out_access_err 0, out_busy 1 (macro on) / 0 (macro off), counter 0.
- Load latency 1: request sampled at edge ending cycle N -> out_rd_word/out_rd_valid valid during N+1, for exactly one cycle.
- Store issued in cycle N is visible to a load issued in cycle N+1 (and in N via write-first).
- Back-to-back loads: one result per cycle, no bubbles.
- Clear duration: out_busy high for exactly DMEM_DEPTH cycles after reset deasserts.
- out_busy is registered (state-derived), never combinational from requests.

## Configuration
- DMEM_CLEAR_ON_RESET_EN defined: CLEAR state and counter present, behaviour as above.
- Undefined: no FSM or counter; block in READY from reset, out_busy tied 0, array contents undefined (X in simulation) until written.

## Structure
- Shared package swt16_dmem_pkg: FSM state encodings (DMEM_ST_CLEAR, DMEM_ST_READY), default widths/depth constants, misalignment-check helper function.
- One sub-module: dmem_ram — single-write-port, single-read-port synchronous array, write-first on same-index collision, registered read data. dmem_resp owns FSM, counter, address decode, write-port mux (clear vs store) and error/valid generation.

## Test plan
- Reset then idle (macro on, DMEM_DEPTH=2048): out_busy=1 for 2048 cycles then 0; loads of 0x000 and 0xFFE return 0x0000.
- Store 0xBEEF to 0x010 in cycle N, load 0x010 in N+1 -> out_rd_word=0xBEEF, out_rd_valid=1 in N+2 only.
- Same-cycle store 0x1234 and load at 0x020 -> next cycle out_rd_word=0x1234; array holds 0x1234.
- Load at 0x011 -> out_access_err=1 one cycle, out_rd_valid=0, out_rd_word unchanged; store 0x5555 to 0x013 leaves array[9] unchanged.
- Store 0xAAAA to 0x004 during CLEAR -> ignored; after busy drops, load 0x004 returns 0x0000.
- Reset asserted at clear counter 1000 -> out_busy stays 1 for full 2048 cycles after reset release; previously stored 0xBEEF at 0x010 reads back 0x0000.
